// File: rtl/cu_pkg.sv
// Shared constants and types for the pipelined control unit.
package cu_pkg;

  // Instruction modes
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  // Data-processing opcodes
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  // ALU commands
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_MUL = 4'b1010;

  // Multi-cycle sequencer states
  typedef enum logic {IDLE, BUSY} state_t;

  // Control word carried through the ID/EX register
  typedef struct packed {
    logic [3:0] exe;
    logic       mem_r;
    logic       mem_w;
    logic       wb;
    logic       b;
    logic       s;
  } ctrl_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction decoder: mode/op_code/S/is_mul -> control word.
module cu_decode
  import cu_pkg::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] op_code,
  input  logic       s,
  input  logic       is_mul,
  output ctrl_t      ctrl
);

  // Decode the instruction fields; reserved mode yields a bubble
  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_DP: begin
        if (is_mul) begin
          ctrl.exe = EXE_MUL;
          ctrl.wb  = 1'b1;
          ctrl.s   = s;
        end else begin
          ctrl.wb = 1'b1;
          ctrl.s  = s;
          case (op_code)
            OP_MOV:  ctrl.exe = EXE_MOV;
            OP_MVN:  ctrl.exe = EXE_MVN;
            OP_ADD:  ctrl.exe = EXE_ADD;
            OP_ADC:  ctrl.exe = EXE_ADC;
            OP_SUB:  ctrl.exe = EXE_SUB;
            OP_SBC:  ctrl.exe = EXE_SBC;
            OP_AND:  ctrl.exe = EXE_AND;
            OP_ORR:  ctrl.exe = EXE_ORR;
            OP_EOR:  ctrl.exe = EXE_EOR;
            OP_CMP: begin
              ctrl.exe = EXE_SUB;
              ctrl.wb  = 1'b0;
              ctrl.s   = 1'b1;
            end
            OP_TST: begin
              ctrl.exe = EXE_AND;
              ctrl.wb  = 1'b0;
              ctrl.s   = 1'b1;
            end
            default: ctrl.exe = EXE_NOP;
          endcase
        end
      end
      MODE_MEM: begin
        ctrl.exe   = EXE_ADD;
        ctrl.mem_r = s;
        ctrl.mem_w = ~s;
        ctrl.wb    = s;
      end
      MODE_BR: begin
        ctrl.b = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX control register with valid/condition gating, freeze/flush and a
// multi-cycle MUL sequencer that holds EX and requests a stall.
module pipelined_control_unit
  import cu_pkg::*;
#(
  parameter int EXE_W   = 4,  // >= 4, upper bits zero
  parameter int MUL_LAT = 3,  // >= 1
  parameter int CNT_W   = 4   // 2**CNT_W > MUL_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             cond_pass,
  input  logic [1:0]       mode,
  input  logic [3:0]       op_code,
  input  logic             s,
  input  logic             is_mul,
  output logic [EXE_W-1:0] exe_cmd_q,
  output logic             mem_r_en_q,
  output logic             mem_w_en_q,
  output logic             wb_en_q,
  output logic             b_q,
  output logic             s_q,
  output logic             mul_busy
);

  // A single-cycle MUL never enters BUSY
  localparam bit MULTI_CYCLE = (MUL_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

  ctrl_t            dec_word;
  ctrl_t            gated_word;
  logic             mul_hit;
  ctrl_t            word_reg, word_next;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  cu_decode u_decode (
    .mode    (mode),
    .op_code (op_code),
    .s       (s),
    .is_mul  (is_mul),
    .ctrl    (dec_word)
  );

  // Squash instructions that are not valid or fail their condition
  always_comb begin
    gated_word = (valid_in && cond_pass) ? dec_word : '0;
    mul_hit    = valid_in && cond_pass && (mode == MODE_DP) && is_mul;
  end

  // Next-state logic: flush > BUSY countdown > freeze hold > load
  always_comb begin
    word_next  = word_reg;
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush) begin
      word_next  = '0;
      state_next = IDLE;
      cnt_next   = '0;
    end else if (state_reg == BUSY) begin
      cnt_next = cnt_reg - 1'b1;
      if (cnt_reg == CNT_W'(1)) begin
        // Last EX cycle of the MUL: result becomes writable
        word_next.wb = 1'b1;
        state_next   = IDLE;
      end
    end else if (!freeze) begin
      word_next = gated_word;
      if (mul_hit && MULTI_CYCLE) begin
        word_next.wb = 1'b0;
        cnt_next     = CNT_LOAD;
        state_next   = BUSY;
      end
    end
  end

  // State and control register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      word_reg  <= '0;
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      word_reg  <= word_next;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Drive the registered control word onto the EX/MEM/WB ports
  always_comb begin
    exe_cmd_q  = EXE_W'(word_reg.exe);
    mem_r_en_q = word_reg.mem_r;
    mem_w_en_q = word_reg.mem_w;
    wb_en_q    = word_reg.wb;
    b_q        = word_reg.b;
    s_q        = word_reg.s;
    mul_busy   = (state_reg == BUSY);
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed self-checking bench for pipelined_control_unit (MUL_LAT = 3).
module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic       flush;
  logic       valid_in;
  logic       cond_pass;
  logic [1:0] mode;
  logic [3:0] op_code;
  logic       s;
  logic       is_mul;
  logic [3:0] exe_cmd_q;
  logic       mem_r_en_q;
  logic       mem_w_en_q;
  logic       wb_en_q;
  logic       b_q;
  logic       s_q;
  logic       mul_busy;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_control_unit #(
    .EXE_W   (4),
    .MUL_LAT (3),
    .CNT_W   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .valid_in   (valid_in),
    .cond_pass  (cond_pass),
    .mode       (mode),
    .op_code    (op_code),
    .s          (s),
    .is_mul     (is_mul),
    .exe_cmd_q  (exe_cmd_q),
    .mem_r_en_q (mem_r_en_q),
    .mem_w_en_q (mem_w_en_q),
    .wb_en_q    (wb_en_q),
    .b_q        (b_q),
    .s_q        (s_q),
    .mul_busy   (mul_busy)
  );

  always #5 clk = ~clk;

  // Observed word: {exe[3:0], mem_r, mem_w, wb, b, s, mul_busy}
  function automatic logic [9:0] obs();
    return {exe_cmd_q, mem_r_en_q, mem_w_en_q, wb_en_q, b_q, s_q, mul_busy};
  endfunction

  function automatic logic [9:0] ew(input logic [3:0] exe, input logic mr, input logic mw,
                                    input logic wb, input logic b, input logic sf,
                                    input logic busy);
    return {exe, mr, mw, wb, b, sf, busy};
  endfunction

  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %-14s got exe/mr/mw/wb/b/s/busy=%b_%b want %b_%b",
               tag, got[9:6], got[5:0], want[9:6], want[5:0]);
    end else begin
      $display("ok   %-14s exe/mr/mw/wb/b/s/busy=%b_%b", tag, got[9:6], got[5:0]);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic [1:0] m, input logic [3:0] op,
                       input logic sb, input logic mul, input logic frz, input logic fl);
    valid_in  = v;
    cond_pass = c;
    mode      = m;
    op_code   = op;
    s         = sb;
    is_mul    = mul;
    freeze    = frz;
    flush     = fl;
  endtask

  // Advance one edge and settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0);
    tick();
    check("reset", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;

    // Basic decode
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("add", obs(), ew(4'b0010, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b1010, 0, 0, 0, 0); tick();
    check("cmp", obs(), ew(4'b0100, 0, 0, 0, 0, 1, 0));
    drive(1, 1, 2'b01, 4'b0000, 1, 0, 0, 0); tick();
    check("ldr", obs(), ew(4'b0010, 1, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b01, 4'b0000, 0, 0, 0, 0); tick();
    check("str", obs(), ew(4'b0010, 0, 1, 0, 0, 0, 0));
    drive(1, 0, 2'b00, 4'b1101, 0, 0, 0, 0); tick();
    check("mov_condfail", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));
    drive(1, 1, 2'b10, 4'b0000, 0, 0, 0, 0); tick();
    check("branch", obs(), ew(4'b0000, 0, 0, 0, 1, 0, 0));
    drive(1, 1, 2'b00, 4'b0100, 1, 0, 0, 0); tick();
    check("adds", obs(), ew(4'b0010, 0, 0, 1, 0, 1, 0));
    drive(1, 1, 2'b00, 4'b1111, 0, 0, 0, 0); tick();
    check("mvn", obs(), ew(4'b1001, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b0001, 0, 0, 0, 0); tick();
    check("eor", obs(), ew(4'b1000, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b1000, 0, 0, 0, 0); tick();
    check("tst", obs(), ew(4'b0110, 0, 0, 0, 0, 1, 0));
    drive(1, 1, 2'b00, 4'b0011, 0, 0, 0, 0); tick();
    check("undef_op", obs(), ew(4'b0000, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b11, 4'b0100, 1, 0, 0, 0); tick();
    check("mode11", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));
    drive(0, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("invalid", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));

    // MUL occupies EX for three cycles, next op loads on the fourth edge
    drive(1, 1, 2'b00, 4'b0000, 1, 1, 0, 0); tick();
    check("mul_c1", obs(), ew(4'b1010, 0, 0, 0, 0, 1, 1));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("mul_c2", obs(), ew(4'b1010, 0, 0, 0, 0, 1, 1));
    tick();
    check("mul_c3", obs(), ew(4'b1010, 0, 0, 1, 0, 1, 0));
    tick();
    check("mul_next", obs(), ew(4'b0010, 0, 0, 1, 0, 0, 0));

    // Freeze holds an ordinary op
    drive(1, 1, 2'b00, 4'b0010, 0, 0, 0, 0); tick();
    check("sub", obs(), ew(4'b0100, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b0000, 0, 0, 1, 0); tick();
    check("freeze1", obs(), ew(4'b0100, 0, 0, 1, 0, 0, 0));
    tick();
    check("freeze2", obs(), ew(4'b0100, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b0000, 0, 0, 0, 0); tick();
    check("and", obs(), ew(4'b0110, 0, 0, 1, 0, 0, 0));

    // Freeze does not stretch a MUL
    drive(1, 1, 2'b00, 4'b0000, 0, 1, 0, 0); tick();
    check("fmul_c1", obs(), ew(4'b1010, 0, 0, 0, 0, 0, 1));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 1, 0); tick();
    check("fmul_c2", obs(), ew(4'b1010, 0, 0, 0, 0, 0, 1));
    tick();
    check("fmul_c3", obs(), ew(4'b1010, 0, 0, 1, 0, 0, 0));
    tick();
    check("fmul_hold", obs(), ew(4'b1010, 0, 0, 1, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("fmul_next", obs(), ew(4'b0010, 0, 0, 1, 0, 0, 0));

    // Flush aborts a MUL in its second cycle
    drive(1, 1, 2'b00, 4'b0000, 1, 1, 0, 0); tick();
    check("xmul_c1", obs(), ew(4'b1010, 0, 0, 0, 0, 1, 1));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("xmul_c2", obs(), ew(4'b1010, 0, 0, 0, 0, 1, 1));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 1); tick();
    check("flush", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("post_flush", obs(), ew(4'b0010, 0, 0, 1, 0, 0, 0));

    // Flush wins over freeze
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 1, 1); tick();
    check("flush_frz", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of a MUL
    drive(1, 1, 2'b00, 4'b0000, 0, 1, 0, 0); tick();
    check("rmul_c1", obs(), ew(4'b1010, 0, 0, 0, 0, 0, 1));
    rst = 1'b0;
    drive(1, 1, 2'b00, 4'b0100, 0, 0, 0, 0); tick();
    check("mid_reset", obs(), ew(4'b0000, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    tick();
    check("post_reset", obs(), ew(4'b0010, 0, 0, 1, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
